// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage MIPS core. It drives the PC
// freeze and the IF/ID and ID/EX pipeline-register strobes. It handles three
// kinds of hazard:
//   - load-use hazards between the load in EX and the instruction in ID,
//   - taken-branch flushes resolved in EX,
//   - the multi-cycle multiply/divide unit (MDU), tracked by a busy counter.
//     A dependent mfhi/mflo, or a second mult/div, is held in ID until the MDU
//     is idle again.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   id_rs, id_rt      source register fields of the instruction in ID
//   id_use_rs/rt      the ID instruction really reads rs / rt
//   id_mdu_start      the ID instruction is mult/multu/div/divu
//   id_mdu_div        1: divide latency, 0: multiply latency
//   id_mdu_read       the ID instruction is mfhi/mflo
//   ex_mem_read       the EX instruction is a load
//   ex_rt             destination register of the EX load
//   ex_branch_taken   a branch/jump resolved taken in EX
//   freeze            hold the PC
//   ifid_freeze       hold the IF/ID register
//   idex_bubble       load a NOP into ID/EX
//   ifid_flush        clear IF/ID to a NOP
//   mdu_busy          the MDU countdown is non-zero
//   stall_cycles      (HAZARD_STATS_EN only) saturating count of freeze cycles
//   flush_count       (HAZARD_STATS_EN only) saturating count of flush cycles
//
// Build option:
//   HAZARD_STATS_EN   when defined, adds the two 32-bit statistics outputs.
//                     Hazard behaviour is the same with or without it.
//
// Parameters:
//   MUL_CYCLES, DIV_CYCLES  MDU latencies (>= 1, and <= 2**CNT_W - 1)
//   CNT_W                   width of the MDU busy counter
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_mdu_start,
   input  logic        id_mdu_div,
   input  logic        id_mdu_read,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        ex_branch_taken,
   output logic        freeze,
   output logic        ifid_freeze,
   output logic        idex_bubble,
   output logic        ifid_flush,
   output logic        mdu_busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_t;

   mdu_state_t       mdu_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic             rs_match;
   logic             rt_match;
   logic             load_use;
   logic             mdu_conflict;
   logic             stall;
   logic             mdu_issue;

   // ---- ID/EX hazard detection (combinational) -----------------------------
   // A load into $zero never creates a real dependency.
   assign rs_match     = id_use_rs && (id_rs == ex_rt);
   assign rt_match     = id_use_rt && (id_rt == ex_rt);
   assign load_use     = ex_mem_read && (ex_rt != 5'd0) && (rs_match || rt_match);
   assign mdu_conflict = mdu_busy && (id_mdu_start || id_mdu_read);

   // The branch flush wins over a stall: the PC must load the branch target,
   // and the instruction in ID is squashed anyway.
   assign stall        = (load_use || mdu_conflict) && !ex_branch_taken;

   assign freeze       = stall;
   assign ifid_freeze  = stall;
   assign idex_bubble  = stall || ex_branch_taken;
   assign ifid_flush   = ex_branch_taken;

   // An MDU op only leaves ID when it is neither stalled nor squashed. While
   // the MDU is busy, mdu_conflict already blocks any new start, so issue
   // never coincides with a non-zero count.
   assign mdu_issue    = id_mdu_start && !stall && !ex_branch_taken;

   // An op already in the MDU is older than the branch in EX, so the
   // countdown keeps running through a flush.
   always_comb begin
      cnt_nxt = cnt;
      if (mdu_issue) begin
         cnt_nxt = id_mdu_div ? DIV_LOAD : MUL_LOAD;
      end else if (cnt != '0) begin
         cnt_nxt = cnt - 1'b1;
      end
   end

   // ---- MDU busy tracking (registered) -------------------------------------
   // The state register mirrors (cnt != 0) so mdu_busy comes straight from a
   // flop; the async reset clears it without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         mdu_state <= MDU_IDLE;
      end else begin
         cnt <= cnt_nxt;
         case (mdu_state)
            MDU_IDLE: if (cnt_nxt != '0) mdu_state <= MDU_BUSY;
            MDU_BUSY: if (cnt_nxt == '0) mdu_state <= MDU_IDLE;
            default:  mdu_state <= MDU_IDLE;
         endcase
      end
   end

   assign mdu_busy = (mdu_state == MDU_BUSY);

`ifdef HAZARD_STATS_EN
   // ---- statistics counters (registered) -----------------------------------
   function automatic logic [31:0] sat_inc32(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (freeze) begin
            stall_cycles <= sat_inc32(stall_cycles);
         end
         if (ifid_flush) begin
            flush_count <= sat_inc32(flush_count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Each cycle the expected output vector
// {freeze, ifid_freeze, idex_bubble, ifid_flush, mdu_busy} is computed from a
// small behavioural model of the hazard equations and MDU countdown, pushed to
// a scoreboard queue, then popped and compared against the DUT mid-cycle.
// Directed scenarios add fixed expectations for stall lengths and count values.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int MUL = 4;
   localparam int DIV = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_use_rs, id_use_rt, id_mdu_start, id_mdu_div, id_mdu_read;
   logic       ex_mem_read, ex_branch_taken;
   logic       freeze, ifid_freeze, idex_bubble, ifid_flush, mdu_busy;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   int   n_checks = 0;
   int   n_pass   = 0;
   int   mcnt     = 0;
   int   exp_stall = 0;
   int   exp_flush = 0;
   logic last_freeze;
   logic [4:0] exp_q[$];

   hazard_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV), .CNT_W(6)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_use_rs       (id_use_rs),
      .id_use_rt       (id_use_rt),
      .id_mdu_start    (id_mdu_start),
      .id_mdu_div      (id_mdu_div),
      .id_mdu_read     (id_mdu_read),
      .ex_mem_read     (ex_mem_read),
      .ex_rt           (ex_rt),
      .ex_branch_taken (ex_branch_taken),
      .freeze          (freeze),
      .ifid_freeze     (ifid_freeze),
      .idex_bubble     (idex_bubble),
      .ifid_flush      (ifid_flush),
      .mdu_busy        (mdu_busy)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_mdu_start = 1'b0; id_mdu_div = 1'b0; id_mdu_read = 1'b0;
      ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
   endtask

   // Called at posedge+1 with inputs already set; returns at next posedge+1.
   task automatic tick(input string tag);
      logic       lu, conf, st, busy;
      logic [4:0] o, e;
      int         nxt;
      lu   = ex_mem_read && (ex_rt != 5'd0) &&
             ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
      busy = (mcnt != 0);
      conf = busy && (id_mdu_start || id_mdu_read);
      st   = (lu || conf) && !ex_branch_taken;
      exp_q.push_back({st, st, st | ex_branch_taken, ex_branch_taken, busy});
      nxt = mcnt;
      if (reset) nxt = 0;
      else if (id_mdu_start && !st && !ex_branch_taken) nxt = id_mdu_div ? DIV : MUL;
      else if (mcnt != 0) nxt = mcnt - 1;
      if (!reset && st) exp_stall++;
      if (!reset && ex_branch_taken) exp_flush++;
      #2;
      o = {freeze, ifid_freeze, idex_bubble, ifid_flush, mdu_busy};
      last_freeze = freeze;
      e = exp_q.pop_front();
      check(tag, 32'(o), 32'(e));
      @(posedge clk);
      mcnt = nxt;
      #1;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      tick("reset_outputs");
      check("reset_cnt", 32'(dut.cnt), 32'd0);
      reset = 1'b0;
      tick("idle");

      // Load-use through rs, then the bubble cycle
      ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
      tick("lu_rs");
      ex_mem_read = 1'b0;
      tick("lu_after_bubble");
      // Load-use through rt; same register but use flag low
      ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1; id_use_rs = 1'b0;
      tick("lu_rt");
      id_use_rt = 1'b0;
      tick("lu_no_use");
      // $zero destination never stalls
      ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
      tick("lu_zero");
      idle_inputs();

      // mult, then dependent mfhi
      id_mdu_start = 1'b1; id_mdu_div = 1'b0;
      tick("mult_issue");
      check("mult_cnt_load", 32'(dut.cnt), 32'd4);
      id_mdu_start = 1'b0; id_mdu_read = 1'b1;
      n = 0;
      do begin
         tick("mfhi_wait");
         if (last_freeze) n++;
      end while (last_freeze && n < 50);
      check("mul_stall_len", 32'(n), 32'd4);
      check("mul_busy_done", 32'(mdu_busy), 32'd0);
      idle_inputs();

      // Branch during load-use stall, with an MDU start squashed
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
      ex_branch_taken = 1'b1; id_mdu_start = 1'b1;
      tick("br_over_stall");
      check("br_no_issue", 32'(dut.cnt), 32'd0);
      idle_inputs();
      tick("after_branch");

      // Back-to-back div
      id_mdu_start = 1'b1; id_mdu_div = 1'b1;
      tick("div1_issue");
      check("div1_cnt_load", 32'(dut.cnt), 32'd32);
      n = 0;
      do begin
         tick("div2_wait");
         if (last_freeze) n++;
      end while (last_freeze && n < 64);
      check("div_stall_len", 32'(n), 32'd32);
      check("div2_cnt_reload", 32'(dut.cnt), 32'd32);
      idle_inputs();
      for (int i = 0; i < 15; i++) tick("div2_count");
      check("div2_cnt_17", 32'(dut.cnt), 32'd17);

      // Asynchronous reset mid-divide
      reset = 1'b1;
      #1;
      check("rst_busy_async", 32'(mdu_busy), 32'd0);
      check("rst_cnt_async", 32'(dut.cnt), 32'd0);
      mcnt = 0; exp_stall = 0; exp_flush = 0;
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      id_mdu_read = 1'b1;
      tick("mfhi_after_rst");
      idle_inputs();

      // Three load-use stalls and two flushes
      for (int i = 0; i < 3; i++) begin
         ex_mem_read = 1'b1; ex_rt = 5'(i + 1); id_rt = 5'(i + 1); id_use_rt = 1'b1;
         tick("stats_lu");
         idle_inputs();
         tick("stats_gap");
      end
      for (int i = 0; i < 2; i++) begin
         ex_branch_taken = 1'b1;
         tick("stats_br");
         ex_branch_taken = 1'b0;
         tick("stats_gap2");
      end
`ifdef HAZARD_STATS_EN
      check("stall_cycles", stall_cycles, 32'd3);
      check("flush_count", flush_count, 32'd2);
      check("stall_model", stall_cycles, 32'(exp_stall));
      check("flush_model", flush_count, 32'(exp_flush));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
